mem_wait_sram: RTL
==================

// Module: mem_wait_sram
// PURPOSE
//  Word-addressed SRAM slave on the core's native memory bus (mem_valid/mem_ready), sitting directly upstream of
//  the riscv core wrapper and feeding it instructions and load data. Inserts a programmable number of wait
//  states so benches and cover runs exercise stalled fetches, loads and stores. Also counts completed
//  instruction fetches and data accesses for cover/assert use.
// PARAMETERS
//  DEPTH_WORDS  1024        number of 32-bit words; power of two, >= 2
//  LATENCY      2           wait cycles between accept and response, 0..15
//  ADDR_BASE    32'h0       byte address of word 0; aligned to 4*DEPTH_WORDS
//  INIT_FILE    ""          hex image loaded with $readmemh at elaboration when non-empty
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  mem_valid  in   1   core request valid
//  mem_instr  in   1   request is an instruction fetch
//  mem_addr   in   32  byte address; bits [1:0] ignored
//  mem_wdata  in   32  store data
//  mem_wstrb  in   4   byte write enables; 0 = read
//  mem_ready  out  1   one-cycle response pulse
//  mem_rdata  out  32  read data, valid while mem_ready=1
//  fault      out  1   pulses with mem_ready when the address was out of range
//  fetch_cnt  out  16  completed in-range fetches, saturating
//  data_cnt   out  16  completed in-range loads+stores, saturating
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, mem_ready=0, fault=0, mem_rdata=0, counters=0, wait counter=0.
//   Memory array is NOT cleared. Request in flight is dropped: no write, no response.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: when mem_valid=1, capture addr/wdata/wstrb/instr, load wait counter with LATENCY;
//    go WAIT if LATENCY>0, else RESP.
//   WAIT: decrement counter each cycle; at counter==1 go RESP. If mem_valid=0 in any WAIT cycle: abort,
//    go IDLE, no write, no response, counters unchanged.
//   RESP: on the edge entering RESP, mem_ready<=1 for exactly one cycle, mem_rdata/fault registered, write
//    committed; then IDLE. mem_valid is ignored in RESP (core drops it after seeing mem_ready).
//  Latency: request accepted in cycle N -> mem_ready high in cycle N+LATENCY+1. Back-to-back requests:
//   earliest next accept is the cycle after mem_ready falls (one idle cycle minimum between requests).
//  Address decode: in range iff ADDR_BASE <= addr < ADDR_BASE+4*DEPTH_WORDS; index = addr[log2(DEPTH)+1:2].
//  Reads (wstrb==0): mem_rdata = word at index (old contents); out of range -> mem_rdata=0, fault=1.
//  Writes: bytes with wstrb[i]=1 take wdata[8i+7:8i], others unchanged; mem_rdata = 0 on writes.
//   Out of range write -> no array update, fault=1.
//  Captured values are used; changes on mem_addr/wdata/wstrb after accept have no effect.
//  mem_rdata holds its last value while mem_ready=0. fault is 0 whenever mem_ready=0.
//  Counters: increment on the RESP entry edge for in-range accesses only; fetch_cnt if captured instr=1,
//   else data_cnt. Saturate at 16'hFFFF (no wrap).
//  mem_instr=1 with wstrb!=0: treated as a write, counted in fetch_cnt.
// TESTING
//  LATENCY=2, word 0 preloaded 32'h00000013; fetch addr 0 accepted cycle 5 -> mem_ready=1 only in cycle 8,
//   rdata=32'h00000013, fault=0, fetch_cnt=1.
//  Store addr 4, wdata 32'hAABBCCDD, wstrb 4'b0101, prior word 32'h11223344 -> later load addr 4 returns
//   32'h11BB33DD, data_cnt=2.
//  LATENCY=0: load accepted cycle N -> mem_ready in cycle N+1; ten back-to-back loads each separated by one
//   idle cycle all complete, data_cnt=10.
//  Load addr ADDR_BASE+4*DEPTH_WORDS -> mem_ready pulse with fault=1, rdata=0, counters unchanged; store to
//   same address leaves array unchanged.
//  LATENCY=3: drop mem_valid in second WAIT cycle -> no mem_ready, no write; assert reset mid-WAIT -> outputs
//   zero immediately, next request after reset completes normally with correct data.
//  Force data_cnt to 16'hFFFE then three in-range loads -> data_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/mem_wait_sram.sv
// Word-addressed SRAM slave for the core's native valid/ready memory bus.
// Adds LATENCY wait states per access and counts completed in-range fetches and data accesses.
module mem_wait_sram #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault,
  output logic [15:0] fetch_cnt,
  output logic [15:0] data_cnt
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT   = 4'(LATENCY);
  localparam logic [32:0] BASE  = {1'b0, ADDR_BASE};
  localparam logic [32:0] LIMIT = BASE + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] data_cnt_q, data_cnt_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          req_instr;
  logic          req_in_range;
  logic [AW-1:0] req_idx;
  logic          commit;
  logic          mem_we;

  // With zero latency the access completes on the accept edge, so the live bus is the request.
  always_comb begin
    if (state_q == S_IDLE) begin
      req_addr  = mem_addr;
      req_wdata = mem_wdata;
      req_wstrb = mem_wstrb;
      req_instr = mem_instr;
    end else begin
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_wstrb = wstrb_q;
      req_instr = instr_q;
    end
  end

  assign req_in_range = ({1'b0, req_addr} >= BASE) && ({1'b0, req_addr} < LIMIT);
  assign req_idx      = req_addr[AW+1:2];
  assign commit       = mem_valid &&
                        (((state_q == S_IDLE) && (LAT == 4'd0)) ||
                         ((state_q == S_WAIT) && (wait_q == 4'd1)));
  assign mem_we       = commit && req_in_range && (req_wstrb != 4'b0000);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    instr_d     = instr_q;
    ready_d     = 1'b0;
    fault_d     = 1'b0;
    rdata_d     = rdata_q;
    fetch_cnt_d = fetch_cnt_q;
    data_cnt_d  = data_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          wait_d  = LAT;
          state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_valid) begin
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
          if (wait_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      ready_d = 1'b1;
      fault_d = !req_in_range;
      rdata_d = (req_in_range && (req_wstrb == 4'b0000)) ? mem_q[req_idx] : 32'h0;
      if (req_in_range) begin
        if (req_instr) begin
          if (fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
        end else begin
          if (data_cnt_q != 16'hFFFF) data_cnt_d = data_cnt_q + 16'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= 4'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      instr_q     <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'h0;
      fetch_cnt_q <= 16'h0;
      data_cnt_q  <= 16'h0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      instr_q     <= instr_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      fetch_cnt_q <= fetch_cnt_d;
      data_cnt_q  <= data_cnt_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) mem_q[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign fault     = fault_q;
  assign fetch_cnt = fetch_cnt_q;
  assign data_cnt  = data_cnt_q;

endmodule
